// File: rtl/vga_sync_receiver.sv
// Recovers column/row position from active-high HSync/VSync, checks line and
// frame timing, and locks after LOCK_FRAMES consecutive good frames.
module vga_sync_receiver #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_HSync,
    input  logic       i_VSync,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Locked,
    output logic       o_Err_Pulse,
    output logic [7:0] o_Err_Count,
    output logic [1:0] o_State_Dbg
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [9:0] COLS    = 10'(TOTAL_COLS);
    localparam logic [9:0] COLS_M1 = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROWS    = 10'(TOTAL_ROWS);
    localparam logic [9:0] ROWS_M1 = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_C   = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_R   = 10'(ACTIVE_ROWS);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

    state_t     state_q, state_d;
    logic [7:0] good_q, good_d;
    logic       hsync_q, vsync_q;
    logic [9:0] col_q, col_d, row_q, row_d;
    logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic       active_q, active_d, locked_q, locked_d;
    logic       err_pulse_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       h_rise, v_rise, line_bad, frame_bad;

    assign h_rise = i_HSync & ~hsync_q;
    assign v_rise = i_VSync & ~vsync_q;

    // A rise at the wrong length is bad; so is the clock where a rise was due but absent.
    assign line_bad  = h_rise ? (line_len_q + 10'd1 != COLS) : (line_len_q == COLS_M1);
    assign frame_bad = (v_rise && (frame_lines_q != ROWS)) || (frame_lines_q > ROWS);
    assign err_d     = (state_q != ST_SEARCH) && (line_bad || frame_bad);

    always_comb begin
        col_d = (col_q == COLS_M1) ? 10'd0 : col_q + 10'd1;
        if (h_rise) col_d = 10'd0;

        row_d = row_q;
        if (v_rise)      row_d = 10'd0;
        else if (h_rise) row_d = (row_q == ROWS_M1) ? 10'd0 : row_q + 10'd1;

        line_len_d = line_len_q;
        if (h_rise)                   line_len_d = 10'd0;
        else if (line_len_q != 10'h3FF) line_len_d = line_len_q + 10'd1;

        // The line that starts together with VSync is the first line of the frame.
        frame_lines_d = frame_lines_q;
        if (v_rise)                                   frame_lines_d = {9'd0, h_rise};
        else if (h_rise && frame_lines_q != 10'h3FF)  frame_lines_d = frame_lines_q + 10'd1;

        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_SEARCH: begin
                if (v_rise) begin
                    state_d = ST_ACQUIRE;
                    good_d  = 8'd0;
                end
            end
            ST_ACQUIRE: begin
                if (err_d) begin
                    state_d = ST_SEARCH;
                end else if (v_rise) begin
                    good_d = good_q + 8'd1;
                    if (good_q + 8'd1 >= LOCK_N) state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (err_d) state_d = ST_SEARCH;
            end
            default: state_d = ST_SEARCH;
        endcase
        locked_d = (state_d == ST_LOCKED);
        active_d = locked_d && (col_d < ACT_C) && (row_d < ACT_R);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= ST_SEARCH;
            good_q        <= 8'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            line_len_q    <= 10'd0;
            frame_lines_q <= 10'd0;
            active_q      <= 1'b0;
            locked_q      <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            hsync_q       <= i_HSync;
            vsync_q       <= i_VSync;
            col_q         <= col_d;
            row_q         <= row_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            active_q      <= active_d;
            locked_q      <= locked_d;
            err_pulse_q   <= err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign o_HSync     = hsync_q;
    assign o_VSync     = vsync_q;
    assign o_Col_Count = col_q;
    assign o_Row_Count = row_q;
    assign o_Active    = active_q;
    assign o_Locked    = locked_q;
    assign o_Err_Pulse = err_pulse_q;
    assign o_Err_Count = err_cnt_q;
    assign o_State_Dbg = state_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: 800-clock lines with a short 4-line frame so that
// many frames fit in the run; a timestamp-based model predicts every output each clock.
module tb_vga_sync_receiver;

    localparam int TOTAL_COLS  = 800;
    localparam int TOTAL_ROWS  = 4;
    localparam int ACTIVE_COLS = 640;
    localparam int ACTIVE_ROWS = 2;
    localparam int LOCK_FRAMES = 2;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b1;
    logic       i_HSync = 1'b0;
    logic       i_VSync = 1'b0;
    logic       o_HSync, o_VSync, o_Active, o_Locked, o_Err_Pulse;
    logic [9:0] o_Col_Count, o_Row_Count;
    logic [7:0] o_Err_Count;
    logic [1:0] o_State_Dbg;

    vga_sync_receiver #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS),
        .ACTIVE_COLS(ACTIVE_COLS),
        .ACTIVE_ROWS(ACTIVE_ROWS),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_HSync    (i_HSync),
        .i_VSync    (i_VSync),
        .o_HSync    (o_HSync),
        .o_VSync    (o_VSync),
        .o_Col_Count(o_Col_Count),
        .o_Row_Count(o_Row_Count),
        .o_Active   (o_Active),
        .o_Locked   (o_Locked),
        .o_Err_Pulse(o_Err_Pulse),
        .o_Err_Count(o_Err_Count),
        .o_State_Dbg(o_State_Dbg)
    );

    always #5 i_Clk = ~i_Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Model: positions from edge timestamps, lock from "synced since last error" plus good-frame tally.
    int m_k, m_last_h, m_lines_in_frame, m_rises_since_v;
    int m_good, m_err_cnt, m_col, m_row;
    bit m_ph, m_pv, m_synced, m_pulse, m_locked, m_active, m_h, m_v;

    task automatic model_reset();
        m_k = 0; m_last_h = 0; m_lines_in_frame = 0; m_rises_since_v = 0;
        m_good = 0; m_err_cnt = 0; m_col = 0; m_row = 0;
        m_ph = 0; m_pv = 0; m_synced = 0; m_pulse = 0; m_locked = 0; m_active = 0;
        m_h = 0; m_v = 0;
    endtask

    task automatic model_edge(input bit h, input bit v);
        bit hr, vr, line_err, frame_err, err;
        m_k++;
        hr = h && !m_ph;
        vr = v && !m_pv;
        line_err  = hr ? (m_k - m_last_h != TOTAL_COLS) : (m_k - m_last_h == TOTAL_COLS);
        frame_err = (vr && m_lines_in_frame != TOTAL_ROWS) || (m_lines_in_frame > TOTAL_ROWS);
        err = m_synced && (line_err || frame_err);
        m_pulse = err;
        if (err) begin
            m_synced = 0;
            if (m_err_cnt < 255) m_err_cnt++;
        end else if (vr) begin
            if (!m_synced) begin
                m_synced = 1;
                m_good = 0;
            end else begin
                m_good++;
            end
        end
        if (hr) m_last_h = m_k;
        if (vr) begin
            m_lines_in_frame = hr ? 1 : 0;
            m_rises_since_v = 0;
        end else if (hr) begin
            m_lines_in_frame++;
            m_rises_since_v++;
        end
        m_col = (m_k - m_last_h) % TOTAL_COLS;
        m_row = m_rises_since_v % TOTAL_ROWS;
        m_locked = m_synced && (m_good >= LOCK_FRAMES);
        m_active = m_locked && (m_col < ACTIVE_COLS) && (m_row < ACTIVE_ROWS);
        m_h = h; m_v = v; m_ph = h; m_pv = v;
    endtask

    task automatic step(input bit h, input bit v);
        i_HSync = h;
        i_VSync = v;
        @(posedge i_Clk);
        model_edge(h, v);
        @(negedge i_Clk);
        check("hsync",     o_HSync,     m_h);
        check("vsync",     o_VSync,     m_v);
        check("col",       o_Col_Count, m_col);
        check("row",       o_Row_Count, m_row);
        check("active",    o_Active,    m_active);
        check("locked",    o_Locked,    m_locked);
        check("err_pulse", o_Err_Pulse, m_pulse);
        check("err_count", o_Err_Count, m_err_cnt);
    endtask

    task automatic drive_line(input int len, input int hs_len, input bit vs, input int start);
        for (int c = start; c < len; c++) step(c < hs_len, vs);
    endtask

    task automatic drive_frame(input int nlines);
        for (int l = 0; l < nlines; l++) drive_line(TOTAL_COLS, ACTIVE_COLS, l < ACTIVE_ROWS, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hsync"},  o_HSync,     0);
        check({tag, "_vsync"},  o_VSync,     0);
        check({tag, "_col"},    o_Col_Count, 0);
        check({tag, "_row"},    o_Row_Count, 0);
        check({tag, "_active"}, o_Active,    0);
        check({tag, "_locked"}, o_Locked,    0);
        check({tag, "_pulse"},  o_Err_Pulse, 0);
        check({tag, "_errcnt"}, o_Err_Count, 0);
        check({tag, "_state"},  o_State_Dbg, 0);
    endtask

    initial begin
        model_reset();
        #2 i_Rst_L = 1'b0;
        @(negedge i_Clk);
        check_all_zero("reset");
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;

        // Acquire and lock: locked one clock after the third VSync rise.
        drive_frame(TOTAL_ROWS);
        drive_frame(TOTAL_ROWS);
        check("locked_before_3rd_vs", o_Locked, 0);
        step(1, 1);
        check("locked_at_3rd_vs", o_Locked, 1);
        check("frame_start_col", o_Col_Count, 0);
        check("frame_start_row", o_Row_Count, 0);
        check("frame_start_hs", o_HSync, 1);
        check("frame_start_vs", o_VSync, 1);
        for (int c = 1; c < TOTAL_COLS; c++) begin
            step(c < ACTIVE_COLS, 1);
            if (c == ACTIVE_COLS - 1) check("active_last_col", o_Active, 1);
            if (c == ACTIVE_COLS) begin
                check("active_drop", o_Active, 0);
                check("active_drop_col", o_Col_Count, ACTIVE_COLS);
            end
        end

        // Short line while locked.
        drive_line(TOTAL_COLS, ACTIVE_COLS, 1 < ACTIVE_ROWS, 0);
        drive_line(TOTAL_COLS - 1, ACTIVE_COLS, 2 < ACTIVE_ROWS, 0);
        step(1, 3 < ACTIVE_ROWS);
        check("short_line_pulse", o_Err_Pulse, 1);
        check("short_line_count", o_Err_Count, 1);
        check("short_line_unlock", o_Locked, 0);
        step(1, 3 < ACTIVE_ROWS);
        check("short_line_pulse_width", o_Err_Pulse, 0);
        drive_line(TOTAL_COLS, ACTIVE_COLS, 3 < ACTIVE_ROWS, 2);

        // Relock after three VSync rises.
        drive_frame(TOTAL_ROWS);
        drive_frame(TOTAL_ROWS);
        check("relock_before", o_Locked, 0);
        step(1, 1);
        check("relock", o_Locked, 1);
        drive_line(TOTAL_COLS, ACTIVE_COLS, 1, 1);

        // HSync missing for 900 clocks.
        step(0, 1 < ACTIVE_ROWS);
        check("missing_hs_pulse", o_Err_Pulse, 1);
        check("missing_hs_count", o_Err_Count, 2);
        check("missing_hs_unlock", o_Locked, 0);
        drive_line(900, 0, 1 < ACTIVE_ROWS, 1);
        drive_line(TOTAL_COLS, ACTIVE_COLS, 2 < ACTIVE_ROWS, 0);
        drive_line(TOTAL_COLS, ACTIVE_COLS, 3 < ACTIVE_ROWS, 0);

        // Frame one line short, observed at the next VSync rise.
        drive_frame(TOTAL_ROWS - 1);
        step(1, 1);
        check("short_frame_pulse", o_Err_Pulse, 1);
        check("short_frame_count", o_Err_Count, 3);
        check("short_frame_locked", o_Locked, 0);
        drive_line(TOTAL_COLS, ACTIVE_COLS, 1, 1);
        for (int l = 1; l < TOTAL_ROWS; l++) drive_line(TOTAL_COLS, ACTIVE_COLS, l < ACTIVE_ROWS, 0);
        drive_frame(TOTAL_ROWS);
        drive_frame(TOTAL_ROWS);
        step(1, 1);
        check("lock_before_reset", o_Locked, 1);
        drive_line(TOTAL_COLS, ACTIVE_COLS, 1, 1);
        drive_line(300, ACTIVE_COLS, 1 < ACTIVE_ROWS, 0);

        // Asynchronous reset mid-line while locked.
        i_Rst_L = 1'b0;
        #1;
        check_all_zero("mid_reset");
        i_HSync = 1'b0;
        i_VSync = 1'b0;
        repeat (2) @(negedge i_Clk);
        check_all_zero("held_reset");
        i_Rst_L = 1'b1;
        model_reset();

        // Randomized frames: occasional off-length lines and frames.
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = ($urandom_range(0, 5) == 0) ? $urandom_range(TOTAL_ROWS - 1, TOTAL_ROWS + 1) : TOTAL_ROWS;
            for (int l = 0; l < nl; l++) begin
                int len, hs;
                len = ($urandom_range(0, 9) == 0) ? $urandom_range(TOTAL_COLS - 3, TOTAL_COLS + 3) : TOTAL_COLS;
                hs  = $urandom_range(1, len - 1);
                drive_line(len, hs, l < ACTIVE_ROWS, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
